// File: rtl/lock_status_regs.sv
// Lock-health status block on the sys bus: free-running 48-bit timestamp
// with coherent high-word shadow, per-PID relock-event counters and sticky
// limiter railed flags. One-cycle request/ack protocol, no back-pressure.
module lock_status_regs (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic [1:0]  railed_a_i,
    input  logic [1:0]  railed_b_i,
    input  logic [3:0]  relock_i,
    input  logic [31:0] sys_addr,
    input  logic [31:0] sys_wdata,
    input  logic        sys_wen,
    input  logic        sys_ren,
    output logic [31:0] sys_rdata,
    output logic        sys_err,
    output logic        sys_ack
);

    // Word index within the 32-byte register window (byte address [4:2])
    typedef enum logic [2:0] {
        REG_CTRL   = 3'd0,
        REG_STICKY = 3'd1,
        REG_TS_LO  = 3'd2,
        REG_TS_HI  = 3'd3,
        REG_CNT0   = 3'd4,
        REG_CNT1   = 3'd5,
        REG_CNT2   = 3'd6,
        REG_CNT3   = 3'd7
    } reg_sel_e;

    logic [47:0]      ts_q;
    logic [15:0]      ts_shadow_q;
    logic             freeze_q;
    logic [3:0]       sticky_q;
    logic [3:0]       relock_q;
    logic [3:0][15:0] relock_cnt;

    logic             addr_hit;
    reg_sel_e         reg_sel;
    logic             req;
    logic             wr_ctrl;
    logic             cnt_clr;
    logic [3:0]       sticky_clr;
    logic [3:0]       sticky_set;
    logic [3:0]       relock_rise;
    logic             ts_lo_rd;
    logic [31:0]      rd_val;

    // Address bits outside the decoded window and unused data bits
    logic             unused_bits;
    assign unused_bits = ^{sys_addr[31:20], sys_addr[1:0], sys_wdata[31:4]};

    // Only the first 32 bytes of the 1 MiB window are mapped
    assign addr_hit    = (sys_addr[19:5] == '0);
    assign reg_sel     = reg_sel_e'(sys_addr[4:2]);
    assign req         = sys_wen | sys_ren;

    // Write-side decode and event detection
    always_comb begin
        wr_ctrl     = sys_wen && addr_hit && (reg_sel == REG_CTRL);
        cnt_clr     = wr_ctrl && sys_wdata[0];
        sticky_clr  = '0;
        if (sys_wen && addr_hit && (reg_sel == REG_STICKY)) begin
            sticky_clr = sys_wdata[3:0];
        end
        sticky_set  = {railed_b_i[1], railed_b_i[0], railed_a_i[1], railed_a_i[0]};
        relock_rise = relock_i & ~relock_q;
        ts_lo_rd    = sys_ren && addr_hit && (reg_sel == REG_TS_LO);
    end

    // Read mux over the pre-update register state
    always_comb begin
        rd_val = '0;
        if (addr_hit) begin
            case (reg_sel)
                REG_CTRL:   rd_val = {30'd0, freeze_q, 1'b0};
                REG_STICKY: rd_val = {28'd0, sticky_q};
                REG_TS_LO:  rd_val = ts_q[31:0];
                REG_TS_HI:  rd_val = {16'd0, ts_shadow_q};
                REG_CNT0:   rd_val = {16'd0, relock_cnt[0]};
                REG_CNT1:   rd_val = {16'd0, relock_cnt[1]};
                REG_CNT2:   rd_val = {16'd0, relock_cnt[2]};
                REG_CNT3:   rd_val = {16'd0, relock_cnt[3]};
                default:    rd_val = '0;
            endcase
        end
    end

    // Free-running timestamp, wraps naturally at 2^48
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            ts_q <= '0;
        end else begin
            ts_q <= ts_q + 48'd1;
        end
    end

    // High-word shadow captured together with every TS_LO read
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            ts_shadow_q <= '0;
        end else if (ts_lo_rd) begin
            ts_shadow_q <= ts_q[47:32];
        end
    end

    // CTRL: FREEZE is a plain level, CNT_CLR is never stored
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            freeze_q <= 1'b0;
        end else if (wr_ctrl) begin
            freeze_q <= sys_wdata[1];
        end
    end

    // Sticky railed flags: set term is applied after the clear so set wins
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            sticky_q <= '0;
        end else begin
            sticky_q <= (sticky_q & ~sticky_clr) | sticky_set;
        end
    end

    // Relock edge detector keeps tracking while frozen, so frozen edges are dropped
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            relock_q <= '0;
        end else begin
            relock_q <= relock_i;
        end
    end

    // Saturating relock counters; a clear overrides a coincident edge
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            relock_cnt <= '0;
        end else begin
            for (int unsigned i = 0; i < 4; i++) begin
                if (cnt_clr) begin
                    relock_cnt[i] <= '0;
                end else if (!freeze_q && relock_rise[i] && (relock_cnt[i] != '1)) begin
                    relock_cnt[i] <= relock_cnt[i] + 16'd1;
                end
            end
        end
    end

    // Bus response one cycle after the request; read data holds until the next read
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            sys_ack   <= 1'b0;
            sys_err   <= 1'b0;
            sys_rdata <= '0;
        end else begin
            sys_ack <= req;
            sys_err <= req && !addr_hit;
            if (sys_ren) begin
                sys_rdata <= rd_val;
            end
        end
    end

endmodule

// File: tb/tb_lock_status_regs.sv
// Self-checking bench for lock_status_regs: directed scenarios plus a
// randomized phase, all compared against a register-level reference model.
module tb_lock_status_regs;

    logic        clk_i = 1'b0;
    logic        rst_i = 1'b1;
    logic [1:0]  railed_a_i = '0;
    logic [1:0]  railed_b_i = '0;
    logic [3:0]  relock_i = '0;
    logic [31:0] sys_addr = '0;
    logic [31:0] sys_wdata = '0;
    logic        sys_wen = 1'b0;
    logic        sys_ren = 1'b0;
    logic [31:0] sys_rdata;
    logic        sys_err;
    logic        sys_ack;

    int vectors = 0;
    int miscompares = 0;

    // Reference model state
    logic [47:0] m_ts;
    logic [15:0] m_cnt [4];
    logic [3:0]  m_sticky;
    logic        m_freeze;
    logic [15:0] m_shadow;
    logic [3:0]  m_prev;
    logic [31:0] exp_rdata;
    logic        exp_ack;
    logic        exp_err;

    lock_status_regs dut (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .railed_a_i (railed_a_i),
        .railed_b_i (railed_b_i),
        .relock_i   (relock_i),
        .sys_addr   (sys_addr),
        .sys_wdata  (sys_wdata),
        .sys_wen    (sys_wen),
        .sys_ren    (sys_ren),
        .sys_rdata  (sys_rdata),
        .sys_err    (sys_err),
        .sys_ack    (sys_ack)
    );

    always #4 clk_i = ~clk_i;

    function automatic logic [31:0] model_read(input int idx);
        case (idx)
            0:       return {30'd0, m_freeze, 1'b0};
            1:       return {28'd0, m_sticky};
            2:       return m_ts[31:0];
            3:       return {16'd0, m_shadow};
            default: return {16'd0, m_cnt[idx-4]};
        endcase
    endfunction

    // One clock: advance the model with the inputs seen at the edge, then settle
    task automatic tick();
        logic [19:0] a;
        bit          hit;
        int          idx;
        bit          clr;
        logic        nf;
        @(posedge clk_i);
        if (rst_i) begin
            m_ts = '0; m_sticky = '0; m_freeze = 1'b0; m_shadow = '0; m_prev = '0;
            for (int i = 0; i < 4; i++) m_cnt[i] = '0;
            exp_ack = 1'b0; exp_err = 1'b0; exp_rdata = '0;
        end else begin
            a   = sys_addr[19:0];
            hit = (a[19:5] == 15'd0);
            idx = int'(a[4:2]);
            exp_ack = sys_wen | sys_ren;
            exp_err = exp_ack && !hit;
            if (sys_ren) exp_rdata = hit ? model_read(idx) : 32'd0;
            clr = sys_wen && hit && idx == 0 && sys_wdata[0];
            nf  = (sys_wen && hit && idx == 0) ? sys_wdata[1] : m_freeze;
            if (sys_ren && hit && idx == 2) m_shadow = m_ts[47:32];
            for (int i = 0; i < 4; i++) begin
                if (clr) m_cnt[i] = 16'd0;
                else if (!m_freeze && relock_i[i] && !m_prev[i] && m_cnt[i] != 16'hFFFF)
                    m_cnt[i] = m_cnt[i] + 16'd1;
            end
            if (sys_wen && hit && idx == 1) m_sticky = m_sticky & ~sys_wdata[3:0];
            m_sticky = m_sticky | {railed_b_i, railed_a_i};
            m_prev   = relock_i;
            m_ts     = m_ts + 48'd1;
            m_freeze = nf;
        end
        #1;
    endtask

    task automatic do_read(input logic [31:0] addr);
        sys_addr = addr; sys_ren = 1'b1;
        tick();
        sys_ren = 1'b0;
    endtask

    task automatic do_write(input logic [31:0] addr, input logic [31:0] data);
        sys_addr = addr; sys_wdata = data; sys_wen = 1'b1;
        tick();
        sys_wen = 1'b0;
    endtask

    task automatic test_reset();
        rst_i = 1'b1;
        repeat (4) tick();
        vectors++;
        if ({sys_ack, sys_err, sys_rdata} !== {exp_ack, exp_err, exp_rdata}) begin
            miscompares++;
            $display("FAIL reset_outputs: got ack=%b err=%b rdata=%h exp 0/0/0", sys_ack, sys_err, sys_rdata);
        end
        rst_i = 1'b0;
        tick();
        for (int i = 0; i < 8; i++) begin
            do_read(32'(i * 4));
            vectors++;
            if (sys_rdata !== exp_rdata || sys_ack !== 1'b1 || sys_err !== 1'b0) begin
                miscompares++;
                $display("FAIL reset_read_%0h: got rdata=%h ack=%b err=%b exp rdata=%h ack=1 err=0",
                         i * 4, sys_rdata, sys_ack, sys_err, exp_rdata);
            end
        end
        tick();
        vectors++;
        if (sys_ack !== 1'b0) begin
            miscompares++;
            $display("FAIL ack_single_cycle: got ack=%b exp 0", sys_ack);
        end
    endtask

    task automatic test_relock();
        for (int p = 0; p < 3; p++) begin
            relock_i[3] = 1'b1; repeat (5) tick();
            relock_i[3] = 1'b0; repeat (5) tick();
        end
        for (int i = 4; i < 8; i++) begin
            do_read(32'(i * 4));
            vectors++;
            if (sys_rdata !== exp_rdata || (i == 7 && sys_rdata !== 32'd3)) begin
                miscompares++;
                $display("FAIL relock_cnt%0d: got %h exp %h", i - 4, sys_rdata, exp_rdata);
            end
        end
        do_write(32'h0, 32'h2);
        for (int p = 0; p < 2; p++) begin
            relock_i[3] = 1'b1; repeat (5) tick();
            relock_i[3] = 1'b0; repeat (5) tick();
        end
        do_read(32'h1C);
        vectors++;
        if (sys_rdata !== exp_rdata) begin
            miscompares++;
            $display("FAIL freeze_hold: got %h exp %h", sys_rdata, exp_rdata);
        end
        do_write(32'h0, 32'h1);
        for (int i = 0; i < 8; i++) begin
            if (i == 1 || i == 2 || i == 3) continue;
            do_read(32'(i * 4));
            vectors++;
            if (sys_rdata !== exp_rdata) begin
                miscompares++;
                $display("FAIL clear_reg_%0h: got %h exp %h", i * 4, sys_rdata, exp_rdata);
            end
        end
    endtask

    task automatic test_saturation();
        relock_i = '0;
        tick();
        // Preload counter 0 close to saturation instead of 65k real edges
        force dut.relock_cnt = {16'h0, 16'h0, 16'h0, 16'hFFFD};
        m_cnt[0] = 16'hFFFD;
        tick();
        release dut.relock_cnt;
        for (int p = 0; p < 6; p++) begin
            relock_i[0] = 1'b1; tick();
            relock_i[0] = 1'b0; tick();
        end
        do_read(32'h10);
        vectors++;
        if (sys_rdata !== exp_rdata || sys_rdata !== 32'h0000FFFF) begin
            miscompares++;
            $display("FAIL saturate: got %h exp %h", sys_rdata, exp_rdata);
        end
        relock_i[0] = 1'b1;
        do_write(32'h0, 32'h1);
        relock_i[0] = 1'b0;
        do_read(32'h10);
        vectors++;
        if (sys_rdata !== exp_rdata) begin
            miscompares++;
            $display("FAIL clear_race: got %h exp %h", sys_rdata, exp_rdata);
        end
    endtask

    task automatic test_sticky();
        railed_b_i[1] = 1'b1; tick();
        railed_b_i[1] = 1'b0; tick();
        for (int k = 0; k < 2; k++) begin
            do_read(32'h4);
            vectors++;
            if (sys_rdata !== exp_rdata || sys_rdata !== 32'h8) begin
                miscompares++;
                $display("FAIL sticky_set_%0d: got %h exp %h", k, sys_rdata, exp_rdata);
            end
            repeat (3) tick();
        end
        railed_b_i[1] = 1'b1;
        do_write(32'h4, 32'h8);
        railed_b_i[1] = 1'b0;
        do_read(32'h4);
        vectors++;
        if (sys_rdata !== exp_rdata) begin
            miscompares++;
            $display("FAIL sticky_set_wins: got %h exp %h", sys_rdata, exp_rdata);
        end
        do_write(32'h4, 32'h8);
        do_read(32'h4);
        vectors++;
        if (sys_rdata !== exp_rdata) begin
            miscompares++;
            $display("FAIL sticky_w1c: got %h exp %h", sys_rdata, exp_rdata);
        end
    endtask

    task automatic test_unmapped_simul();
        do_read(32'h20);
        vectors++;
        if (sys_rdata !== exp_rdata || sys_ack !== exp_ack || sys_err !== exp_err) begin
            miscompares++;
            $display("FAIL unmapped_read: got rdata=%h ack=%b err=%b exp %h/%b/%b",
                     sys_rdata, sys_ack, sys_err, exp_rdata, exp_ack, exp_err);
        end
        do_write(32'h0008_0004, 32'hF);
        vectors++;
        if (sys_ack !== exp_ack || sys_err !== exp_err) begin
            miscompares++;
            $display("FAIL unmapped_write: got ack=%b err=%b exp %b/%b", sys_ack, sys_err, exp_ack, exp_err);
        end
        railed_a_i = 2'b11; tick();
        railed_a_i = 2'b00;
        do_read(32'hFFF0_0004);
        vectors++;
        if (sys_rdata !== exp_rdata || sys_err !== 1'b0) begin
            miscompares++;
            $display("FAIL alias_read: got %h err=%b exp %h err=0", sys_rdata, sys_err, exp_rdata);
        end
        sys_addr = 32'h4; sys_wdata = 32'hF; sys_wen = 1'b1; sys_ren = 1'b1;
        tick();
        sys_wen = 1'b0; sys_ren = 1'b0;
        vectors++;
        if (sys_rdata !== exp_rdata || sys_rdata !== 32'h3 || sys_ack !== 1'b1) begin
            miscompares++;
            $display("FAIL simul_rw: got rdata=%h ack=%b exp %h ack=1", sys_rdata, sys_ack, exp_rdata);
        end
        tick();
        vectors++;
        if (sys_ack !== 1'b0) begin
            miscompares++;
            $display("FAIL simul_one_ack: got ack=%b exp 0", sys_ack);
        end
        do_read(32'h4);
        vectors++;
        if (sys_rdata !== exp_rdata) begin
            miscompares++;
            $display("FAIL simul_after: got %h exp %h", sys_rdata, exp_rdata);
        end
    endtask

    task automatic test_reset_edge();
        rst_i = 1'b1;
        relock_i = 4'b0010;
        repeat (3) tick();
        rst_i = 1'b0;
        repeat (3) tick();
        relock_i = '0;
        do_read(32'h14);
        vectors++;
        if (sys_rdata !== exp_rdata) begin
            miscompares++;
            $display("FAIL reset_edge: got %h exp %h", sys_rdata, exp_rdata);
        end
    endtask

    task automatic test_random();
        int    r;
        int    w;
        logic  rd;
        for (int n = 0; n < 800; n++) begin
            if ($urandom_range(0, 3) == 0) relock_i = relock_i ^ 4'($urandom);
            railed_a_i = ($urandom_range(0, 15) == 0) ? 2'($urandom) : 2'b00;
            railed_b_i = ($urandom_range(0, 15) == 0) ? 2'($urandom) : 2'b00;
            r = $urandom_range(0, 9);
            sys_ren = (r < 4 || r == 8);
            sys_wen = ((r >= 4 && r < 7) || r == 8);
            w = $urandom_range(0, 10);
            sys_addr = {12'($urandom), 20'(w * 4)} | 32'($urandom_range(0, 3));
            if (w == 10) sys_addr[19:0] = 20'h4000C;
            sys_wdata = $urandom;
            if (w == 0 && $urandom_range(0, 3) != 0) sys_wdata[0] = 1'b0;
            rd = sys_ren;
            tick();
            sys_ren = 1'b0; sys_wen = 1'b0;
            vectors++;
            if (sys_ack !== exp_ack || sys_err !== exp_err || (rd && sys_rdata !== exp_rdata)) begin
                miscompares++;
                $display("FAIL random_%0d: got ack=%b err=%b rdata=%h exp %b/%b/%h",
                         n, sys_ack, sys_err, sys_rdata, exp_ack, exp_err, exp_rdata);
            end
        end
    endtask

    // Runs last: the forced timestamp leaves the model's timestamp behind
    task automatic test_timestamp();
        logic [31:0] lo;
        sys_addr = 32'h8; sys_ren = 1'b1;
        force dut.ts_q = 48'h1234_FFFF_FFFF;
        tick();
        release dut.ts_q;
        sys_ren = 1'b0;
        vectors++;
        if (sys_rdata !== 32'hFFFF_FFFF) begin
            miscompares++;
            $display("FAIL ts_lo_wrap: got %h exp ffffffff", sys_rdata);
        end
        do_read(32'hC);
        vectors++;
        if (sys_rdata !== 32'h1234) begin
            miscompares++;
            $display("FAIL ts_hi_shadow: got %h exp 00001234", sys_rdata);
        end
        repeat (5) tick();
        do_read(32'hC);
        vectors++;
        if (sys_rdata !== 32'h1234) begin
            miscompares++;
            $display("FAIL ts_hi_stable: got %h exp 00001234", sys_rdata);
        end
        do_read(32'h8);
        lo = sys_rdata;
        do_read(32'hC);
        vectors++;
        if (sys_rdata !== 32'h1235 || lo > 32'h100) begin
            miscompares++;
            $display("FAIL ts_after_wrap: got hi=%h lo=%h exp hi=00001235 lo<100", sys_rdata, lo);
        end
    endtask

    initial begin
        test_reset();
        test_relock();
        test_saturation();
        test_sticky();
        test_unmapped_simul();
        test_reset_edge();
        test_random();
        test_timestamp();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/lock_status_regs.md
# lock_status_regs

System-bus responder exposing lock-health statistics for the four MIMO PID sections and the output limiter: a 48-bit timestamp, per-PID relock-event counters and sticky railed flags. It sits beside the PID and limit blocks on the sys bus, serving the same request/ack protocol that the bus initiator drives, and gives software a race-free view of lock events without polling the PID registers.

## Interface
- No parameters; widths fixed.
- clk_i  input  1  ADC clock, 125 MHz
- rst_i  input  1  synchronous, active-high reset
- railed_a_i  input  2  limiter railed flags, output A: [0] lower, [1] upper
- railed_b_i  input  2  limiter railed flags, output B: [0] lower, [1] upper
- relock_i  input  4  per-PID relock-search active, bit index = PID11, PID12, PID21, PID22
- sys_addr  input  32  byte address; decode on [19:0], [1:0] ignored
- sys_wdata  input  32  write data
- sys_wen  input  1  write request, single-cycle pulse
- sys_ren  input  1  read request, single-cycle pulse
- sys_rdata  output  32  read data
- sys_err  output  1  unmapped-address error, valid with sys_ack
- sys_ack  output  1  request completion, single-cycle pulse

## Operation
- Register map (unused bits read 0, writes to RO ignored):
  - 0x00 CTRL RW: [0] CNT_CLR write-1 self-clearing (reads 0); [1] FREEZE level.
  - 0x04 STICKY RW1C [3:0] = {b_upper, b_lower, a_upper, a_lower}.
  - 0x08 TS_LO RO: timestamp[31:0]; read also latches timestamp[47:32] of the same cycle into TS_HI shadow.
  - 0x0C TS_HI RO: shadow[15:0].
  - 0x10/0x14/0x18/0x1C RELOCK_CNT0..3 RO [15:0].
  - Any other address: sys_err=1 with ack, no side effect, sys_rdata=0.
- Timestamp: 48-bit free-running, +1 per cycle, wraps 2^48-1 -> 0; unaffected by CNT_CLR and FREEZE.
- Relock counters: relock_q registered copy of relock_i; rising edge = relock_i & ~relock_q; counter +1 per edge, saturates at 0xFFFF.
- FREEZE=1: edges ignored (counters hold); edge detector still updates relock_q, so edges during freeze are lost, not deferred.
- CNT_CLR write: all four counters -> 0; clear beats a simultaneous edge (result 0).
- STICKY: bit set on any cycle its railed input is 1; write-1 clears. Set and clear in same cycle: set wins.
- wen and ren in same cycle: write performed, one ack, sys_rdata returns pre-write value of addressed register.

## Timing
- Reset (rst_i=1 at posedge): timestamp=0, counters=0, STICKY=0, CTRL=0, shadow=0, relock_q=0, sys_ack=0, sys_err=0, sys_rdata=0.
- Input held high across reset release counts as one edge on first cycle out of reset.
- Request at cycle N -> sys_ack (and sys_err if unmapped) high in cycle N+1 only; sys_rdata valid in N+1, holds until next read.
- Read data reflects register state at cycle N (before any cycle-N updates); TS_LO returns timestamp value of cycle N.
- Write effect visible to reads issued at N+1 or later; CNT_CLR clears counters at edge ending cycle N.
- No back-pressure; requests on consecutive cycles each acked one cycle later.
- Railed/relock inputs sampled every cycle; no input synchronisers (same clock domain).

## Test plan
- Reset: drive rst_i 4 cycles, read 0x00..0x1C -> all 0 except TS_LO small nonzero; sys_err=0 each, ack exactly one cycle after each request.
- Relock counting: pulse relock_i[3] high 3 times (5 cycles high, 5 low) -> RELOCK_CNT3=3, others 0; set FREEZE, 2 more pulses -> still 3; write CTRL=1 -> all counters 0, CTRL reads 0 (FREEZE cleared).
- Saturation/clear race: force 65 540 edges on relock_i[0] -> CNT0=0xFFFF; write CNT_CLR in the cycle of an edge -> CNT0=0.
- Sticky: pulse railed_b_i[1] one cycle -> STICKY=0x8 persistent; write 0x8 while railed_b_i[1]=1 -> still 0x8; deassert then write 0x8 -> 0.
- Timestamp coherence: preload timestamp to 0x0000_FFFF_FFFF (hierarchical force), read TS_LO in wrap cycle then TS_HI -> pair equals value at TS_LO request; subsequent TS_HI read unchanged until next TS_LO read.
- Unmapped/simultaneous: read 0x20 -> ack+err, rdata 0; wen+ren to 0x04 with wdata 0xF after flags set -> rdata=old flags, then STICKY=0.
